// File: rtl/column_scheduler_if.sv
// Column scheduler bus: player controls in, column/score state out.
interface column_scheduler_if;
  logic       start;
  logic [7:0] user_input;
  logic [7:0] letter1;
  logic [7:0] letter2;
  logic [7:0] letter3;
  logic [4:0] ypos1;
  logic [4:0] ypos2;
  logic [4:0] ypos3;
  logic [2:0] active;
  logic [7:0] score;
  logic       correct;
  logic       game_over;
  logic [1:0] state;

  modport master (
    output start, user_input,
    input  letter1, letter2, letter3,
    input  ypos1, ypos2, ypos3,
    input  active, score, correct,
    input  game_over, state
  );

  modport slave (
    input  start, user_input,
    output letter1, letter2, letter3,
    output ypos1, ypos2, ypos3,
    output active, score, correct,
    output game_over, state
  );
endinterface

// File: rtl/column_scheduler.sv
// Falling-letter game core: three columns, tick pacing, LFSR spawn,
// switch matching, saturating score and speed-up.
module column_scheduler #(
  parameter int TICK_INIT  = 25000000,
  parameter int TICK_MIN   = 5000000,
  parameter int TICK_STEP  = 2500000,
  parameter int BOTTOM_ROW = 29,
  parameter int SPAWN_GAP  = 8
) (
  input logic clock,
  input logic reset_signal,
  column_scheduler_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t      st;
  logic [7:0]  lfsr;
  logic [7:0]  prev_in;
  logic [7:0]  score_q;
  logic [7:0]  let_q [3];
  logic [4:0]  row_q [3];
  logic [2:0]  live;
  logic [31:0] period;
  logic [31:0] pend;
  logic [31:0] cnt;
  logic        correct_q;
  logic        over_q;

  logic [7:0]  let_n [3];
  logic [4:0]  row_n [3];
  logic [2:0]  live_n;
  logic        evt;
  logic        step;
  logic        hit;
  logic        bottom;
  logic        gap_ok;
  logic        spawned;
  logic        speed;
  logic [1:0]  win;
  logic [7:0]  score_inc;
  logic [31:0] pend_n;

  assign evt  = (bus.user_input != prev_in) &&
                (bus.user_input != 8'd0);
  assign step = (st == PLAY) && (cnt == period - 32'd1);

  // Deepest matching column wins; strict compare keeps ties on low index.
  always_comb begin
    hit = 1'b0;
    win = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (evt && live[i] &&
          let_q[i] == bus.user_input &&
          (!hit || row_q[i] > row_q[win])) begin
        hit = 1'b1;
        win = 2'(i);
      end
    end
  end

  assign score_inc = score_q + 8'd1;
  assign speed = hit && (score_q != 8'hFF) &&
                 (score_inc[2:0] == 3'd0);

  always_comb begin
    pend_n = pend;
    if (speed) begin
      if (pend >= 32'(TICK_MIN + TICK_STEP))
        pend_n = pend - 32'(TICK_STEP);
      else
        pend_n = 32'(TICK_MIN);
    end
  end

  // Clear first, then bottom test, then move and spawn.
  always_comb begin
    let_n   = let_q;
    row_n   = row_q;
    live_n  = live;
    bottom  = 1'b0;
    gap_ok  = 1'b1;
    spawned = 1'b0;
    if (hit) begin
      let_n[win]  = 8'd0;
      row_n[win]  = 5'd0;
      live_n[win] = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      if (live_n[i] && row_n[i] == 5'(BOTTOM_ROW))
        bottom = 1'b1;
      if (live_n[i] &&
          32'(row_n[i]) + 32'd1 < 32'(SPAWN_GAP))
        gap_ok = 1'b0;
    end
    if (step && !bottom) begin
      for (int i = 0; i < 3; i++) begin
        if (live_n[i])
          row_n[i] = row_n[i] + 5'd1;
      end
      for (int i = 0; i < 3; i++) begin
        if (gap_ok && !spawned && !live_n[i]) begin
          spawned   = 1'b1;
          live_n[i] = 1'b1;
          let_n[i]  = lfsr;
          row_n[i]  = 5'd0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_signal) begin
      st        <= IDLE;
      lfsr      <= 8'hA5;
      prev_in   <= 8'd0;
      score_q   <= 8'd0;
      live      <= 3'd0;
      correct_q <= 1'b0;
      over_q    <= 1'b0;
      period    <= 32'(TICK_INIT);
      pend      <= 32'(TICK_INIT);
      cnt       <= 32'd0;
      for (int i = 0; i < 3; i++) begin
        let_q[i] <= 8'd0;
        row_q[i] <= 5'd0;
      end
    end else begin
      lfsr      <= {lfsr[6:0],
                    lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      prev_in   <= bus.user_input;
      correct_q <= 1'b0;
      unique case (st)
        PLAY: begin
          let_q <= let_n;
          row_q <= row_n;
          live  <= live_n;
          pend  <= pend_n;
          if (hit) begin
            correct_q <= 1'b1;
            if (score_q != 8'hFF)
              score_q <= score_inc;
          end
          if (step) begin
            cnt    <= 32'd0;
            period <= pend_n;
            if (bottom) begin
              st     <= OVER;
              over_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        IDLE, OVER: begin
          if (bus.start) begin
            st       <= PLAY;
            over_q   <= 1'b0;
            score_q  <= 8'd0;
            period   <= 32'(TICK_INIT);
            pend     <= 32'(TICK_INIT);
            cnt      <= 32'd0;
            live     <= 3'b001;
            let_q[0] <= lfsr;
            row_q[0] <= 5'd0;
            for (int i = 1; i < 3; i++) begin
              let_q[i] <= 8'd0;
              row_q[i] <= 5'd0;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.letter1   = let_q[0];
  assign bus.letter2   = let_q[1];
  assign bus.letter3   = let_q[2];
  assign bus.ypos1     = row_q[0];
  assign bus.ypos2     = row_q[1];
  assign bus.ypos3     = row_q[2];
  assign bus.active    = live;
  assign bus.score     = score_q;
  assign bus.correct   = correct_q;
  assign bus.game_over = over_q;
  assign bus.state     = st;
endmodule

// File: doc/column_scheduler.md
Name: column_scheduler

Overview:
Game controller for the three falling letter columns feeding the Display block. It owns the per-column letter and row state and paces the fall with a programmable tick. It spawns letters from an LFSR, matches switch input against live letters, keeps score and speeds up play. Its letter1..3 and ypos1..3 outputs drive Display directly; game_over and correct drive LEDs.

Parameters:
TICK_INIT, 25000000, initial clocks per fall step (0.5 s at 50 MHz)
TICK_MIN, 5000000, floor for the step period
TICK_STEP, 2500000, period decrement per speed-up
BOTTOM_ROW, 29, last visible row (40x30 text grid)
SPAWN_GAP, 8, minimum rows every active column must have fallen before the next spawn

Ports:
clock  in  1  system clock (CLOCK_50)
reset_signal  in  1  reset; synchronous, active-low
start  in  1  level; begins or restarts a game
user_input  in  8  switch letter code
letter1, letter2, letter3  out  8  letter per column (0 when inactive)
ypos1, ypos2, ypos3  out  5  row per column (0 when inactive)
active  out  3  bit i = column i+1 live
score  out  8  letters cleared, saturating
correct  out  1  one-cycle pulse on a match
game_over  out  1  high in OVER
state  out  2  0 IDLE, 1 PLAY, 2 OVER

Behaviour:
- Reset (reset_signal=0 at a clock edge) applies in any state:
  - state goes to IDLE.
  - letters, ypos, active, score, correct and game_over all go to 0.
  - period goes to TICK_INIT; tick counter goes to 0.
  - LFSR is seeded to 8'hA5; prev_input goes to 0.
- LFSR: 8-bit Fibonacci with taps 8,6,5,4. It advances every clock in every state and is never 0.
- IDLE, start=1 for one edge:
  - Next state is PLAY.
  - Column 1 spawns at ypos 0 with letter = current LFSR value.
  - Tick counter is cleared.
- PLAY, tick:
  - Counter counts 0..period-1 and wraps.
  - The wrap cycle is a step pulse; first step comes period clocks after entry.
  - A new period value is loaded only at wrap; the counter is never reset by a speed change.
- PLAY, step (applied in priority order):
  - 1) A match clear in the same cycle is applied first.
  - 2) If any remaining active column has ypos == BOTTOM_ROW: state goes to OVER, game_over goes to 1, and no movement occurs.
  - 3) Otherwise every remaining active column does ypos+1.
  - 4) Spawn rule: if at least one column is inactive and every active column has post-move ypos >= SPAWN_GAP (vacuously true when none are active), the lowest-index inactive column spawns at ypos 0 with letter = LFSR.
  - At most one spawn per step.
- PLAY, match:
  - user_input is registered into prev_input every clock.
  - An input event is user_input != prev_input with user_input != 0.
  - On an event, candidates are active columns whose letter == user_input.
  - Winner is the candidate with the largest ypos; ties go to the lowest index.
  - The winner is cleared: active=0, letter=0, ypos=0.
  - score increments, saturating at 255; correct pulses high for exactly that cycle.
  - No candidate means no effect; there is no penalty.
  - One clear per event. Duplicate letters need separate events.
- Speed-up: when an increment makes score[2:0]==0, period becomes max(period-TICK_STEP, TICK_MIN).
- OVER:
  - All outputs are frozen; tick and match are ignored.
  - start=1 clears score, letters and active, sets period to TICK_INIT, spawns column 1 as in IDLE, and goes to PLAY.
- start held high in PLAY has no effect.
- Output latency: all outputs are registered and reflect an event on the clock edge that processes it.

Test Plan:
- Reset: TICK_INIT=4. Assert reset_signal=0 mid-PLAY -> next edge: state=0, active=000, score=0, ypos1=0, letter1=0, game_over=0.
- Fall/spawn: TICK_INIT=4, SPAWN_GAP=2, start pulse.
  - active becomes 001 with letter1 != 0.
  - After 4 clocks, ypos1=1; after 8 clocks, ypos1=2 and column 2 spawns in the same edge (active=011, ypos2=0).
- Match priority: force col1 ypos=5 and col2 ypos=9, both with letter 8'h3C. Set user_input=8'h3C.
  - Column 2 clears; correct pulses 1 cycle; score 0->1.
  - Holding the input gives no further clear.
  - Toggling to 0 and back to 8'h3C clears column 1 (score=2).
- Game over: BOTTOM_ROW=3, no input -> on the step with ypos1==3: state=2, game_over=1, ypos1 stays 3, and later steps change nothing.
- Clear-vs-bottom race: match column 1 at ypos==BOTTOM_ROW in the same cycle as the step -> column 1 clears, score+1, state stays PLAY.
- Speed-up and restart: TICK_INIT=20, TICK_STEP=8, TICK_MIN=6.
  - 8 matches -> period 12; 16 matches -> period 6 (floored); step spacing is measured as 12 then 6 clocks.
  - start in OVER -> score=0, period back to 20.
